// File: rtl/lerp_pkg.sv
// lerp_pkg: shared types and constants for the lerp_upsampler block.
`default_nettype none

package lerp_pkg;

  localparam int DEF_DATA_WIDTH  = 14;
  localparam int DEF_SAMPLE_RATE = 4;

  function automatic int clog2(input int value);
    int n;
    n = 0;
    while ((1 << n) < value) n = n + 1;
    return n;
  endfunction

  localparam int L = clog2(DEF_SAMPLE_RATE);

  typedef logic signed [DEF_DATA_WIDTH-1:0] sample_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRIME = 2'd1,
    RUN   = 2'd2,
    HOLD  = 2'd3
  } state_t;

endpackage

`default_nettype wire

// File: rtl/lerp_core.sv
// lerp_core: combinational x0/x1/k -> y datapath.
// INTERP_LINEAR_EN selects linear interpolation; otherwise zero-order hold (y = x0).
`default_nettype none

module lerp_core
  import lerp_pkg::*;
#(
  parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int SAMPLE_RATE = DEF_SAMPLE_RATE
) (
  input  logic signed [DATA_WIDTH-1:0]         i_x0,
`ifdef INTERP_LINEAR_EN
  input  logic signed [DATA_WIDTH-1:0]         i_x1,
  input  logic        [clog2(SAMPLE_RATE)-1:0] i_k,
`endif
  output logic signed [DATA_WIDTH-1:0]         o_y
);

`ifdef INTERP_LINEAR_EN
  localparam int c_kw = clog2(SAMPLE_RATE);
  localparam int c_pw = DATA_WIDTH + 1 + c_kw;

  logic signed [DATA_WIDTH:0] w_d;
  logic signed [c_pw-1:0]     w_p;
  logic signed [c_pw-1:0]     w_q;

  assign w_d = (DATA_WIDTH+1)'(i_x1) - (DATA_WIDTH+1)'(i_x0);
  assign w_p = c_pw'(w_d) * $signed(c_pw'({1'b0, i_k}));
  // Arithmetic shift floors toward -inf; the result always lies between x0 and x1.
  assign w_q = w_p >>> c_kw;
  assign o_y = DATA_WIDTH'(c_pw'(i_x0) + w_q);
`else
  assign o_y = i_x0;
`endif

endmodule

`default_nettype wire

// File: rtl/lerp_upsampler.sv
// lerp_upsampler: FIFO-fed xR upsampler with prime/run/hold FSM and underrun recovery.
// Interpolation mode is selected by INTERP_LINEAR_EN (see lerp_core).
`default_nettype none

module lerp_upsampler
  import lerp_pkg::*;
#(
  parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int SAMPLE_RATE = DEF_SAMPLE_RATE
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         fifo_almst_full,
  input  logic                         fifo_empty,
  input  logic signed [DATA_WIDTH-1:0] fifo_dout,
  output logic                         fifo_rd_en,
  output logic signed [DATA_WIDTH-1:0] dac_data,
  output logic                         dac_valid,
  output logic                         underrun
);

  localparam int               c_kw            = clog2(SAMPLE_RATE);
  localparam logic [c_kw-1:0]  c_k_last        = c_kw'(SAMPLE_RATE - 1);
  localparam logic [c_kw-1:0]  c_k_fetch       = c_kw'(SAMPLE_RATE - 2);
  localparam logic             c_fetch_at_wrap = (SAMPLE_RATE == 2);

  state_t                      r_state;
  logic [c_kw-1:0]             r_k;
  logic signed [DATA_WIDTH-1:0] r_x0;
  logic signed [DATA_WIDTH-1:0] r_x1;
  logic                        r_rd_en;
  logic                        r_pend;
  logic                        r_got_x0;
  logic [1:0]                  r_prime_rd;
  logic signed [DATA_WIDTH-1:0] r_dac_data;
  logic                        r_dac_valid;
  logic                        r_underrun;
  logic signed [DATA_WIDTH-1:0] w_y;
  logic [c_kw-1:0]             w_k_inc;

  assign w_k_inc = r_k + 1'b1;

  lerp_core #(
    .DATA_WIDTH  (DATA_WIDTH),
    .SAMPLE_RATE (SAMPLE_RATE)
  ) u_core (
    .i_x0 (r_x0),
`ifdef INTERP_LINEAR_EN
    .i_x1 (r_x1),
    .i_k  (r_k),
`endif
    .o_y  (w_y)
  );

  // r_pend marks that fifo_dout carries the word requested by last cycle's strobe.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= IDLE;
      r_k         <= '0;
      r_x0        <= '0;
      r_x1        <= '0;
      r_rd_en     <= 1'b0;
      r_pend      <= 1'b0;
      r_got_x0    <= 1'b0;
      r_prime_rd  <= '0;
      r_dac_data  <= '0;
      r_dac_valid <= 1'b0;
      r_underrun  <= 1'b0;
    end else begin
      r_pend      <= r_rd_en;
      r_rd_en     <= 1'b0;
      r_underrun  <= 1'b0;
      r_dac_valid <= (r_state == RUN) || (r_state == HOLD);
      case (r_state)
        IDLE: begin
          r_dac_data <= '0;
          if (fifo_almst_full) begin
            r_state    <= PRIME;
            r_prime_rd <= '0;
            r_got_x0   <= 1'b0;
          end
        end
        PRIME: begin
          r_dac_data <= '0;
          if (r_prime_rd != 2'd2 && !fifo_empty) begin
            r_rd_en    <= 1'b1;
            r_prime_rd <= r_prime_rd + 2'd1;
          end
          if (r_pend) begin
            if (!r_got_x0) begin
              r_x0     <= fifo_dout;
              r_got_x0 <= 1'b1;
            end else begin
              r_x1    <= fifo_dout;
              r_k     <= '0;
              r_state <= RUN;
              r_rd_en <= c_fetch_at_wrap && !fifo_empty;
            end
          end
        end
        RUN: begin
          r_dac_data <= w_y;
          if (r_k == c_k_last) begin
            if (r_pend) begin
              r_x0    <= r_x1;
              r_x1    <= fifo_dout;
              r_k     <= '0;
              r_rd_en <= c_fetch_at_wrap && !fifo_empty;
            end else begin
              r_underrun <= 1'b1;
              r_state    <= HOLD;
            end
          end else begin
            r_k     <= w_k_inc;
            r_rd_en <= (w_k_inc == c_k_fetch) && !fifo_empty;
          end
        end
        HOLD: begin
          r_dac_data <= r_x1;
          if (r_pend) begin
            r_x0    <= r_x1;
            r_x1    <= fifo_dout;
            r_k     <= '0;
            r_state <= RUN;
            r_rd_en <= c_fetch_at_wrap && !fifo_empty;
          end else if (!r_rd_en && !fifo_empty) begin
            r_rd_en <= 1'b1;
          end
        end
        default: begin
          r_dac_data <= '0;
          r_state    <= IDLE;
        end
      endcase
    end
  end

  assign fifo_rd_en = r_rd_en;
  assign dac_data   = r_dac_data;
  assign dac_valid  = r_dac_valid;
  assign underrun   = r_underrun;

endmodule

`default_nettype wire

// File: tb/tb_lerp_upsampler.sv
// tb_lerp_upsampler: directed self-checking bench for lerp_upsampler (R=4, 14-bit).
// Expected tables follow INTERP_LINEAR_EN the same way the design does.
`default_nettype none

module tb_lerp_upsampler;

  localparam int DW = 14;

  logic                 clk = 1'b0;
  logic                 rst = 1'b0;
  logic                 fifo_almst_full = 1'b0;
  logic                 fifo_empty = 1'b1;
  logic signed [DW-1:0] fifo_dout = '0;
  logic                 fifo_rd_en;
  logic signed [DW-1:0] dac_data;
  logic                 dac_valid;
  logic                 underrun;

  int checks = 0;
  int errors = 0;
  int q[$];

  always #5 clk = ~clk;

  lerp_upsampler #(
    .DATA_WIDTH  (DW),
    .SAMPLE_RATE (4)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .fifo_almst_full (fifo_almst_full),
    .fifo_empty      (fifo_empty),
    .fifo_dout       (fifo_dout),
    .fifo_rd_en      (fifo_rd_en),
    .dac_data        (dac_data),
    .dac_valid       (dac_valid),
    .underrun        (underrun)
  );

  // One clock; the FIFO model pops on a strobe seen before the edge, data valid after it.
  task automatic tick();
    logic rd;
    rd = fifo_rd_en;
    @(posedge clk);
    #1;
    if (rd) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL rd_while_empty: fifo_rd_en=1, required 0 while FIFO empty");
      end else begin
        fifo_dout = DW'(q.pop_front());
      end
    end
    fifo_empty = (q.size() == 0);
  endtask

  task automatic push(input int v);
    q.push_back(v);
    fifo_empty = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    fifo_almst_full = 1'b0;
    q.delete();
    fifo_empty = 1'b1;
    fifo_dout = '0;
    tick();
    tick();
    rst = 1'b1;
    tick();
  endtask

  // Leaves the bench just after E0, the edge that samples almst_full.
  task automatic start();
    fifo_almst_full = 1'b1;
    tick();
    fifo_almst_full = 1'b0;
  endtask

  task automatic test_reset();
    tick();
    checks += 4;
    if (dac_data !== '0) begin errors++; $display("FAIL reset_data: got %0d, required 0", dac_data); end
    if (dac_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b, required 0", dac_valid); end
    if (fifo_rd_en !== 1'b0) begin errors++; $display("FAIL reset_rd_en: got %b, required 0", fifo_rd_en); end
    if (underrun !== 1'b0) begin errors++; $display("FAIL reset_underrun: got %b, required 0", underrun); end
    rst = 1'b1;
    push(5);
    for (int i = 0; i < 4; i++) begin
      tick();
      checks += 2;
      if (fifo_rd_en !== 1'b0) begin errors++; $display("FAIL idle_rd_en[%0d]: got %b, required 0", i, fifo_rd_en); end
      if (dac_valid !== 1'b0) begin errors++; $display("FAIL idle_valid[%0d]: got %b, required 0", i, dac_valid); end
    end
  endtask

  task automatic test_prime();
    int exp_rd[13];
    int exp_d[8];
    exp_rd = '{0, 1, 1, 0, 0, 0, 1, 0, 0, 0, 1, 0, 0};
`ifdef INTERP_LINEAR_EN
    exp_d = '{0, 25, 50, 75, 100, 125, 150, 175};
`else
    exp_d = '{0, 0, 0, 0, 100, 100, 100, 100};
`endif
    do_reset();
    push(0); push(100); push(200); push(300); push(400);
    start();
    for (int i = 0; i <= 12; i++) begin
      if (i > 0) tick();
      checks += 3;
      if (fifo_rd_en !== exp_rd[i][0]) begin
        errors++; $display("FAIL prime_rd_en[E%0d]: got %b, required %0d", i, fifo_rd_en, exp_rd[i]);
      end
      if (dac_valid !== (i >= 5)) begin
        errors++; $display("FAIL prime_valid[E%0d]: got %b, required %0d", i, dac_valid, (i >= 5));
      end
      if (dac_data !== DW'((i >= 5) ? exp_d[i-5] : 0)) begin
        errors++; $display("FAIL prime_data[E%0d]: got %0d, required %0d", i, dac_data, (i >= 5) ? exp_d[i-5] : 0);
      end
    end
  endtask

  task automatic test_interp();
    int exp_d[16];
`ifdef INTERP_LINEAR_EN
    exp_d = '{-8, -4, 0, 4, 8, 4, 0, -4, -8, -8, -8, -8, -7, -8, -8, -8};
`else
    exp_d = '{-8, -8, -8, -8, 8, 8, 8, 8, -8, -8, -8, -8, -7, -7, -7, -7};
`endif
    do_reset();
    push(-8); push(8); push(-8); push(-7); push(-8);
    start();
    for (int i = 1; i <= 4; i++) tick();
    for (int i = 0; i < 16; i++) begin
      tick();
      checks += 2;
      if (dac_valid !== 1'b1) begin errors++; $display("FAIL interp_valid[%0d]: got %b, required 1", i, dac_valid); end
      if (dac_data !== DW'(exp_d[i])) begin
        errors++; $display("FAIL interp_data[%0d]: got %0d, required %0d", i, dac_data, exp_d[i]);
      end
    end
  endtask

  task automatic test_extremes();
    int exp_d[8];
`ifdef INTERP_LINEAR_EN
    exp_d = '{8191, 4095, -1, -4097, -8192, -4097, -1, 4095};
`else
    exp_d = '{8191, 8191, 8191, 8191, -8192, -8192, -8192, -8192};
`endif
    do_reset();
    push(8191); push(-8192); push(8191);
    start();
    for (int i = 1; i <= 4; i++) tick();
    for (int i = 0; i < 8; i++) begin
      tick();
      checks++;
      if (dac_data !== DW'(exp_d[i])) begin
        errors++; $display("FAIL extreme_data[%0d]: got %0d, required %0d", i, dac_data, exp_d[i]);
      end
    end
  endtask

  task automatic test_underrun();
    int exp_a[4];
    int exp_b[4];
    int rd_count;
`ifdef INTERP_LINEAR_EN
    exp_a = '{0, 25, 50, 75};
    exp_b = '{100, 125, 150, 175};
`else
    exp_a = '{0, 0, 0, 0};
    exp_b = '{100, 100, 100, 100};
`endif
    do_reset();
    push(0); push(100);
    start();
    for (int i = 1; i <= 4; i++) tick();
    for (int i = 0; i < 4; i++) begin
      tick();
      checks += 3;
      if (dac_data !== DW'(exp_a[i])) begin errors++; $display("FAIL ur_run_data[%0d]: got %0d, required %0d", i, dac_data, exp_a[i]); end
      if (underrun !== (i == 3)) begin errors++; $display("FAIL ur_pulse[%0d]: got %b, required %0d", i, underrun, (i == 3)); end
      if (fifo_rd_en !== 1'b0) begin errors++; $display("FAIL ur_no_read[%0d]: got %b, required 0", i, fifo_rd_en); end
    end
    for (int i = 0; i < 10; i++) begin
      tick();
      checks += 4;
      if (dac_data !== DW'(100)) begin errors++; $display("FAIL hold_data[%0d]: got %0d, required 100", i, dac_data); end
      if (dac_valid !== 1'b1) begin errors++; $display("FAIL hold_valid[%0d]: got %b, required 1", i, dac_valid); end
      if (underrun !== 1'b0) begin errors++; $display("FAIL hold_underrun[%0d]: got %b, required 0", i, underrun); end
      if (fifo_rd_en !== 1'b0) begin errors++; $display("FAIL hold_rd_en[%0d]: got %b, required 0", i, fifo_rd_en); end
    end
    push(200);
    rd_count = 0;
    for (int i = 0; i < 7; i++) begin
      tick();
      if (fifo_rd_en === 1'b1) rd_count++;
      checks += 2;
      if (fifo_rd_en !== (i == 0)) begin errors++; $display("FAIL resume_rd_en[%0d]: got %b, required %0d", i, fifo_rd_en, (i == 0)); end
      if (dac_data !== DW'((i < 3) ? 100 : exp_b[i-3])) begin
        errors++; $display("FAIL resume_data[%0d]: got %0d, required %0d", i, dac_data, (i < 3) ? 100 : exp_b[i-3]);
      end
    end
    checks++;
    if (rd_count != 1) begin errors++; $display("FAIL resume_read_count: got %0d, required 1", rd_count); end
  endtask

  task automatic test_async_reset();
    do_reset();
    push(40); push(80); push(120); push(160);
    start();
    for (int i = 1; i <= 5; i++) tick();
    checks += 2;
    if (dac_data !== DW'(40)) begin errors++; $display("FAIL pre_rst_data: got %0d, required 40", dac_data); end
    if (dac_valid !== 1'b1) begin errors++; $display("FAIL pre_rst_valid: got %b, required 1", dac_valid); end
    #2;
    rst = 1'b0;
    #1;
    checks += 4;
    if (dac_data !== '0) begin errors++; $display("FAIL async_data: got %0d, required 0", dac_data); end
    if (dac_valid !== 1'b0) begin errors++; $display("FAIL async_valid: got %b, required 0", dac_valid); end
    if (fifo_rd_en !== 1'b0) begin errors++; $display("FAIL async_rd_en: got %b, required 0", fifo_rd_en); end
    if (underrun !== 1'b0) begin errors++; $display("FAIL async_underrun: got %b, required 0", underrun); end
    tick();
    rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks += 2;
      if (fifo_rd_en !== 1'b0) begin errors++; $display("FAIL post_rst_rd_en[%0d]: got %b, required 0", i, fifo_rd_en); end
      if (dac_valid !== 1'b0) begin errors++; $display("FAIL post_rst_valid[%0d]: got %b, required 0", i, dac_valid); end
    end
    start();
    for (int i = 1; i <= 4; i++) begin
      tick();
      checks++;
      if (dac_valid !== 1'b0) begin errors++; $display("FAIL reprime_valid[E%0d]: got %b, required 0", i, dac_valid); end
    end
    tick();
    checks += 2;
    if (dac_valid !== 1'b1) begin errors++; $display("FAIL reprime_first_valid: got %b, required 1", dac_valid); end
    if (dac_data !== DW'(120)) begin errors++; $display("FAIL reprime_first_data: got %0d, required 120", dac_data); end
    tick();
    checks++;
`ifdef INTERP_LINEAR_EN
    if (dac_data !== DW'(130)) begin errors++; $display("FAIL reprime_second_data: got %0d, required 130", dac_data); end
`else
    if (dac_data !== DW'(120)) begin errors++; $display("FAIL reprime_second_data: got %0d, required 120", dac_data); end
`endif
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_prime();
    test_interp();
    test_extremes();
    test_underrun();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
